// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the video
// fetch path and two clients.
//   clk, reset          : clock, asynchronous active-high reset
//   p_tick, video_on,
//   x, y                : pixel tick, visible-area flag and pixel position
//   c0_*/c1_*           : client request, command fields, grant, read valid
//   cli_rdata           : client read data (mirror of mem_rdata)
//   mem_*               : RAM port; reads return one cycle after mem_en
//   vid_data            : last tile byte fetched for the renderer
//   frame_start         : one-cycle pulse after a tick at pixel (0,0)
module vram_arbiter #(
    parameter int unsigned ADDR_W        = 13,
    parameter int unsigned DATA_W        = 8,
    parameter bit          WR_BLANK_ONLY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c0_gnt,
    output logic              c1_gnt,
    output logic              c0_rvalid,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] cli_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] vid_data,
    output logic              frame_start
);

    localparam int unsigned TILE_W = 13;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_C0   = 2'd2,
        OWN_C1   = 2'd3
    } owner_e;

    owner_e              owner_d, owner_q;
    logic                ptr_d, ptr_q;          // 0: c0 preferred, 1: c1 preferred
    logic                rd_d, rd_q;            // granted client access was a read
    logic [DATA_W-1:0]   vid_data_d, vid_data_q;
    logic                frame_start_d, frame_start_q;

    logic                vid_slot;
    logic                wr_ok;
    logic                c0_elig, c1_elig;
    logic [TILE_W-1:0]   tile_addr;

    // 80x60 tile map, 8x8 pixels per tile
    assign tile_addr = {y[8:3], x[9:3]};
    assign vid_slot  = p_tick & video_on;

    // Writes may be held off during the visible area
    assign wr_ok   = ~WR_BLANK_ONLY | ~video_on;
    assign c0_elig = c0_req & (~c0_we | wr_ok);
    assign c1_elig = c1_req & (~c1_we | wr_ok);

    // Owner state register and pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= OWN_NONE;
            ptr_q         <= 1'b0;
            rd_q          <= 1'b0;
            vid_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            rd_q          <= rd_d;
            vid_data_q    <= vid_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Cycle ownership decision and RAM port drive
    always_comb begin
        owner_d   = OWN_NONE;
        ptr_d     = ptr_q;
        rd_d      = 1'b0;
        c0_gnt    = 1'b0;
        c1_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (reset) begin
            owner_d = OWN_NONE;
        end else if (vid_slot) begin
            owner_d  = OWN_VID;
            mem_en   = 1'b1;
            mem_addr = ADDR_W'(tile_addr);
        end else if (c0_elig && (!ptr_q || !c1_elig)) begin
            owner_d   = OWN_C0;
            c0_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = c0_we;
            mem_addr  = c0_addr;
            mem_wdata = c0_wdata;
            rd_d      = ~c0_we;
            ptr_d     = 1'b1;
        end else if (c1_elig) begin
            owner_d   = OWN_C1;
            c1_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = c1_we;
            mem_addr  = c1_addr;
            mem_wdata = c1_wdata;
            rd_d      = ~c1_we;
            ptr_d     = 1'b0;
        end

        // Video fetch data lands one cycle after the video slot
        vid_data_d    = (owner_q == OWN_VID) ? mem_rdata : vid_data_q;
        frame_start_d = p_tick && (x == 10'd0) && (y == 10'd0);
    end

    assign c0_rvalid   = (owner_q == OWN_C0) & rd_q;
    assign c1_rvalid   = (owner_q == OWN_C1) & rd_q;
    assign cli_rdata   = mem_rdata;
    assign vid_data    = vid_data_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: table vectors, directed corner sequences and a
// randomized run checked against a behavioural arbitration model.
module tb_vram_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          p_tick, video_on;
    logic [9:0]    x, y;
    logic          c0_req, c0_we, c1_req, c1_we;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [DW-1:0] cli_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] vid_data;
    logic          frame_start;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_BLANK_ONLY(1'b1)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
        .cli_rdata(cli_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .vid_data(vid_data),
        .frame_start(frame_start)
    );

    // Synchronous RAM, one-cycle read latency
    logic          fill;
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= DW'(i * 37 + 11);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=video 2=c0 3=c1
    int            m_pref;
    int            m_own;
    bit            m_rv0, m_rv1, m_rv0_n, m_rv1_n;
    logic [DW-1:0] m_rdexp, m_rdcap;
    bit            m_vpend;
    logic [DW-1:0] m_vcap, m_vcap_n, m_vid;
    bit            m_fs, m_fs_n;

    task automatic check_only();
        bit            vid;
        bit            e [2];
        int            order [2];
        int            own;
        logic [AW-1:0] vaddr, ad;
        logic [DW-1:0] wd;
        bit            we;
        vid      = p_tick && video_on;
        e[0]     = c0_req && !(c0_we && video_on);
        e[1]     = c1_req && !(c1_we && video_on);
        order[0] = m_pref;
        order[1] = 1 - m_pref;
        own      = 0;
        if (reset)    own = 0;
        else if (vid) own = 1;
        else for (int k = 0; k < 2; k++) if (own == 0 && e[order[k]]) own = 2 + order[k];
        vaddr = AW'(((int'(y) / 8) % 64) * 128 + int'(x) / 8);
        ad    = (own == 1) ? vaddr : (own == 2) ? c0_addr : (own == 3) ? c1_addr : '0;
        wd    = (own == 2) ? c0_wdata : (own == 3) ? c1_wdata : '0;
        we    = (own == 2) ? c0_we : (own == 3) ? c1_we : 1'b0;
        chk("c0_gnt", 32'(c0_gnt), 32'(own == 2));
        chk("c1_gnt", 32'(c1_gnt), 32'(own == 3));
        chk("mem_en", 32'(mem_en), 32'(own != 0));
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_addr", 32'(mem_addr), 32'(ad));
        chk("mem_wdata", 32'(mem_wdata), 32'(wd));
        chk("c0_rvalid", 32'(c0_rvalid), 32'(m_rv0));
        chk("c1_rvalid", 32'(c1_rvalid), 32'(m_rv1));
        if (m_rv0 || m_rv1) chk("cli_rdata", 32'(cli_rdata), 32'(m_rdexp));
        chk("vid_data", 32'(vid_data), 32'(m_vid));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        m_own    = own;
        m_rv0_n  = (own == 2) && !c0_we;
        m_rv1_n  = (own == 3) && !c1_we;
        m_rdcap  = (own >= 2) ? ram[ad] : '0;
        m_vcap_n = (own == 1) ? ram[vaddr] : '0;
        m_fs_n   = !reset && p_tick && x == 10'd0 && y == 10'd0;
    endtask

    task automatic commit();
        if (reset) begin
            m_pref = 0; m_rv0 = 0; m_rv1 = 0; m_vpend = 0; m_vid = '0; m_fs = 0; m_own = 0;
        end else begin
            if (m_vpend) m_vid = m_vcap;
            m_vpend = (m_own == 1);
            m_vcap  = m_vcap_n;
            m_rv0   = m_rv0_n;
            m_rv1   = m_rv1_n;
            m_rdexp = m_rdcap;
            m_fs    = m_fs_n;
            if (m_own == 2)      m_pref = 1;
            else if (m_own == 3) m_pref = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic drv_vid(input bit t, input bit v, input logic [9:0] xx, input logic [9:0] yy);
        p_tick = t; video_on = v; x = xx; y = yy;
    endtask

    task automatic drv_c0(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c0_req = r; c0_we = w; c0_addr = a; c0_wdata = d;
    endtask

    task automatic drv_c1(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c1_req = r; c1_we = w; c1_addr = a; c1_wdata = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        commit();
        #1;
        check_only();
        chk("rst_c0_gnt", 32'(c0_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_vid_data", 32'(vid_data), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        bit            tick, von;
        logic [9:0]    xx, yy;
        bit            r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        bit            r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        bit            g0, g1, en, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
    } vec_t;

    vec_t vt [8];

    bit            rq [2];
    bit            wq [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] dq [2];
    int            vcnt;

    initial begin
        vt[0] = '{1'b1, 1'b1, 10'd16, 10'd8, 1'b1, 1'b0, 13'd5, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00,
                  1'b0, 1'b0, 1'b1, 1'b0, 13'h082, 8'h00};
        vt[1] = '{1'b0, 1'b1, 10'd16, 10'd8, 1'b1, 1'b0, 13'd5, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00,
                  1'b1, 1'b0, 1'b1, 1'b0, 13'd5, 8'h00};
        vt[2] = '{1'b0, 1'b0, 10'd16, 10'd8, 1'b1, 1'b0, 13'd7, 8'h00, 1'b1, 1'b0, 13'd9, 8'h00,
                  1'b0, 1'b1, 1'b1, 1'b0, 13'd9, 8'h00};
        vt[3] = '{1'b0, 1'b0, 10'd16, 10'd8, 1'b1, 1'b0, 13'd7, 8'h00, 1'b1, 1'b0, 13'd10, 8'h00,
                  1'b1, 1'b0, 1'b1, 1'b0, 13'd7, 8'h00};
        vt[4] = '{1'b0, 1'b1, 10'd16, 10'd8, 1'b1, 1'b1, 13'h020, 8'hAB, 1'b1, 1'b0, 13'd10, 8'h00,
                  1'b0, 1'b1, 1'b1, 1'b0, 13'd10, 8'h00};
        vt[5] = '{1'b0, 1'b1, 10'd16, 10'd8, 1'b1, 1'b1, 13'h020, 8'hAB, 1'b0, 1'b0, 13'd0, 8'h00,
                  1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 8'h00};
        vt[6] = '{1'b1, 1'b0, 10'd16, 10'd8, 1'b1, 1'b1, 13'h020, 8'hAB, 1'b0, 1'b0, 13'd0, 8'h00,
                  1'b1, 1'b0, 1'b1, 1'b1, 13'h020, 8'hAB};
        vt[7] = '{1'b1, 1'b1, 10'd639, 10'd479, 1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00,
                  1'b0, 1'b0, 1'b1, 1'b0, 13'h1DCF, 8'h00};

        reset = 1'b1; fill = 1'b1;
        drv_vid(1'b0, 1'b0, 10'd0, 10'd0);
        drv_c0(1'b1, 1'b0, 13'd1, 8'h00);   // request held during reset must not be granted
        drv_c1(1'b0, 1'b0, 13'd0, 8'h00);
        commit();
        @(negedge clk);
        do_reset();
        fill = 1'b0;
        drv_c0(1'b0, 1'b0, 13'd0, 8'h00);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            drv_vid(vt[i].tick, vt[i].von, vt[i].xx, vt[i].yy);
            drv_c0(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0);
            drv_c1(vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
            #1;
            check_only();
            chk($sformatf("tbl%0d_c0_gnt", i), 32'(c0_gnt), 32'(vt[i].g0));
            chk($sformatf("tbl%0d_c1_gnt", i), 32'(c1_gnt), 32'(vt[i].g1));
            chk($sformatf("tbl%0d_mem_en", i), 32'(mem_en), 32'(vt[i].en));
            chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(vt[i].we));
            chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].ad));
            chk($sformatf("tbl%0d_mem_wdata", i), 32'(mem_wdata), 32'(vt[i].wd));
            step();
        end
        drv_c0(1'b0, 1'b0, 13'd0, 8'h00);
        drv_c1(1'b0, 1'b0, 13'd0, 8'h00);

        // Video slot defers a client read; rvalid follows the client slot
        do_reset();
        drv_vid(1'b1, 1'b1, 10'd16, 10'd8);
        drv_c0(1'b1, 1'b0, 13'd5, 8'h00);
        #1; check_only();
        chk("vdefer_addr", 32'(mem_addr), 32'h082);
        chk("vdefer_gnt", 32'(c0_gnt), 32'd0);
        step();
        drv_vid(1'b0, 1'b1, 10'd17, 10'd8);
        #1; check_only();
        chk("vdefer_late_gnt", 32'(c0_gnt), 32'd1);
        chk("vdefer_late_addr", 32'(mem_addr), 32'd5);
        step();
        drv_c0(1'b0, 1'b0, 13'd0, 8'h00);
        #1; check_only();
        chk("vdefer_rvalid", 32'(c0_rvalid), 32'd1);
        chk("vdefer_rdata", 32'(cli_rdata), 32'hC4);
        step();

        // Round-robin alternation in blanking
        do_reset();
        drv_c0(1'b1, 1'b0, 13'd100, 8'h00);
        drv_c1(1'b1, 1'b0, 13'd200, 8'h00);
        for (int k = 0; k < 8; k++) begin
            drv_vid(k % 4 == 0, 1'b0, 10'd100, 10'd100);
            #1; check_only();
            chk($sformatf("rr%0d", k), 32'({c0_gnt, c1_gnt}), (k % 2 == 0) ? 32'd2 : 32'd1);
            step();
        end
        drv_c0(1'b0, 1'b0, 13'd0, 8'h00);
        drv_c1(1'b0, 1'b0, 13'd0, 8'h00);

        // Video fetch data lands two cycles after the tick and holds
        drv_vid(1'b0, 1'b0, 10'd0, 10'd5);
        drv_c0(1'b1, 1'b1, 13'h082, 8'h5A);
        #1; check_only(); step();
        drv_c0(1'b0, 1'b0, 13'd0, 8'h00);
        drv_vid(1'b1, 1'b1, 10'd16, 10'd8);
        #1; check_only(); step();
        for (int j = 1; j <= 5; j++) begin
            drv_vid(1'b0, 1'b1, 10'(16 + j), 10'd8);
            #1; check_only();
            if (j >= 2) chk($sformatf("vid_hold_t%0d", j), 32'(vid_data), 32'h5A);
            step();
        end

        // Frame start pulse
        drv_vid(1'b1, 1'b0, 10'd0, 10'd0);
        #1; check_only(); step();
        drv_vid(1'b0, 1'b0, 10'd0, 10'd0);
        #1; check_only();
        chk("fs_pulse", 32'(frame_start), 32'd1);
        step();
        drv_vid(1'b1, 1'b0, 10'd0, 10'd1);
        #1; check_only();
        chk("fs_one_cycle", 32'(frame_start), 32'd0);
        step();
        drv_vid(1'b0, 1'b0, 10'd4, 10'd1);
        #1; check_only();
        chk("fs_y1_none", 32'(frame_start), 32'd0);
        step();

        // Reset right after a c1 read grant drops the rvalid
        drv_c0(1'b1, 1'b0, 13'd3, 8'h00);
        #1; check_only(); step();
        drv_c0(1'b0, 1'b0, 13'd0, 8'h00);
        drv_c1(1'b1, 1'b0, 13'd4, 8'h00);
        #1; check_only();
        chk("rst_c1_granted", 32'(c1_gnt), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_c1_rvalid_now", 32'(c1_rvalid), 32'd0);
        step();
        drv_c1(1'b0, 1'b0, 13'd0, 8'h00);
        reset = 1'b0;
        #1; check_only();
        chk("rst_c1_rvalid_after", 32'(c1_rvalid), 32'd0);
        step();

        // Pointer returns to c0 after reset
        drv_c0(1'b1, 1'b0, 13'd3, 8'h00);
        #1; check_only(); step();
        drv_c0(1'b0, 1'b0, 13'd0, 8'h00);
        do_reset();
        drv_c0(1'b1, 1'b0, 13'd6, 8'h00);
        drv_c1(1'b1, 1'b0, 13'd8, 8'h00);
        #1; check_only();
        chk("rst_ptr_c0", 32'({c0_gnt, c1_gnt}), 32'd2);
        step();

        // Randomized run
        for (int k = 0; k < 2; k++) begin rq[k] = 0; wq[k] = 0; aq[k] = '0; dq[k] = '0; end
        m_own = 0;
        vcnt  = 0;
        video_on = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (vcnt == 0) begin
                video_on = ~video_on;
                vcnt     = $urandom_range(20, 200);
            end else begin
                vcnt--;
            end
            p_tick = (n % 4 == 0);
            if ($urandom_range(0, 15) == 0) begin
                x = 10'd0;
                y = 10'($urandom_range(0, 1));
            end else begin
                x = 10'($urandom_range(0, 799));
                y = 10'($urandom_range(0, 524));
            end
            for (int k = 0; k < 2; k++) begin
                if (!rq[k] || m_own == 2 + k) begin
                    if ($urandom_range(0, 9) < 6) begin
                        rq[k] = 1;
                        wq[k] = ($urandom_range(0, 2) == 0);
                        aq[k] = AW'($urandom);
                        dq[k] = DW'($urandom);
                    end else begin
                        rq[k] = 0;
                    end
                end
            end
            drv_c0(rq[0], wq[0], aq[0], dq[0]);
            drv_c1(rq[1], wq[1], aq[1], dq[1]);
            #1;
            check_only();
            if ($urandom_range(0, 799) == 0) reset = 1'b1;
            step();
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
